// File: rtl/toggle_event_decoder.sv
// Receive side of a toggle-encoded event line: synchronizes tog_in, turns each level
// change into a one-cycle pulse, and queues events in a saturating pending counter.
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 4,
    parameter int TOTAL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tog_in,
    input  logic                   evt_ready,
    input  logic                   clr_overflow,
    output logic                   evt_valid,
    output logic                   evt_pulse,
    output logic [CNT_WIDTH-1:0]   pending,
    output logic [TOTAL_WIDTH-1:0] total,
    output logic                   overflow,
    output logic                   level,
    output logic                   armed
);

    localparam logic [CNT_WIDTH-1:0] PEND_MAX  = '1;
    localparam logic [2:0]           INIT_LAST = 3'(SYNC_STAGES);

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic [2:0]             init_cnt;
    logic                   run;
    logic                   detect;
    logic                   pop;

    // Saturating up/down step; a simultaneous detect and pop cancel out.
    function automatic logic [CNT_WIDTH-1:0] pending_step(
        input logic [CNT_WIDTH-1:0] cur,
        input logic                 det,
        input logic                 take
    );
        logic [CNT_WIDTH-1:0] nxt;
        nxt = cur;
        if (det && !take && cur != PEND_MAX)
            nxt = cur + CNT_WIDTH'(1);
        else if (take && !det)
            nxt = cur - CNT_WIDTH'(1);
        return nxt;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sync <= '0;
        else
            sync <= {sync[SYNC_STAGES-2:0], tog_in};
    end

    assign level = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == INIT)
                init_cnt <= init_cnt + 3'd1;
        end
    end

    // INIT lasts SYNC_STAGES+1 edges so prev has absorbed the settled initial level.
    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (init_cnt == INIT_LAST) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    assign run       = (state == RUN);
    assign armed     = run;
    assign evt_valid = (pending != '0);
    assign detect    = run && (level ^ prev);
    assign pop       = run && evt_valid && evt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev      <= 1'b0;
            evt_pulse <= 1'b0;
            pending   <= '0;
            total     <= '0;
            overflow  <= 1'b0;
        end else begin
            prev      <= level;
            evt_pulse <= detect;
            pending   <= pending_step(pending, detect, pop);
            if (detect)
                total <= total + TOTAL_WIDTH'(1);
            // A new saturated event takes priority over a coincident clear.
            if (detect && !pop && pending == PEND_MAX)
                overflow <= 1'b1;
            else if (clr_overflow && run)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Scoreboard bench for toggle_event_decoder: stimulus pushes expected pulse-time state,
// a negedge monitor pops and compares whenever evt_pulse is presented.
module tb_toggle_event_decoder;

    logic       clk;
    logic       rst;
    logic       tog_in;
    logic       evt_ready;
    logic       clr_overflow;
    logic       evt_valid;
    logic       evt_pulse;
    logic [3:0] pending;
    logic [7:0] total;
    logic       overflow;
    logic       level;
    logic       armed;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int pend;
        int tot;
        int ovf;
    } exp_t;

    exp_t sb[$];

    toggle_event_decoder #(
        .SYNC_STAGES(2),
        .CNT_WIDTH(4),
        .TOTAL_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tog_in(tog_in),
        .evt_ready(evt_ready),
        .clr_overflow(clr_overflow),
        .evt_valid(evt_valid),
        .evt_pulse(evt_pulse),
        .pending(pending),
        .total(total),
        .overflow(overflow),
        .level(level),
        .armed(armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int p, input int t, input int o);
        exp_t e;
        e.pend = p;
        e.tot  = t;
        e.ovf  = o;
        sb.push_back(e);
    endtask

    // One event: the pulse lands two edges after the first sampling edge, well inside 4 ticks.
    task automatic send(input int p, input int t, input int o);
        push(p, t, o);
        tog_in = ~tog_in;
        repeat (4) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pending"}, pending, 0);
        check({tag, "_total"}, total, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_pulse"}, evt_pulse, 0);
        check({tag, "_valid"}, evt_valid, 0);
        check({tag, "_armed"}, armed, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && evt_pulse) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got pulse with pending=%0d total=%0d, expected none",
                         pending, total);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_pending", pending, e.pend);
                check("pulse_total", total, e.tot);
                check("pulse_overflow", overflow, e.ovf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        tog_in       = 1'b1;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");

        // Test 1: initial level absorbed, armed at the third edge after release
        rst = 1'b0;
        repeat (2) tick();
        check("init_armed_low", armed, 0);
        tick();
        check("init_armed_high", armed, 1);
        repeat (3) tick();
        check("init_pending", pending, 0);
        check("init_total", total, 0);

        // Test 2: exact latency of a single event
        push(1, 1, 0);
        tog_in = ~tog_in;
        repeat (2) tick();
        check("lat_early", evt_pulse, 0);
        tick();
        check("lat_pulse", evt_pulse, 1);
        check("lat_valid", evt_valid, 1);
        check("lat_total", total, 1);
        tick();
        check("lat_pulse_end", evt_pulse, 0);
        check("lat_pending_hold", pending, 1);

        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("drain1_pending", pending, 0);
        check("drain1_valid", evt_valid, 0);

        // Test 3: five events queued, then drained one per cycle
        for (int i = 1; i <= 5; i++) send(i, 1 + i, 0);
        check("q5_pending", pending, 5);
        evt_ready = 1'b1;
        for (int i = 4; i >= -1; i--) begin
            tick();
            check("drain_pending", pending, (i < 0) ? 0 : i);
            check("drain_valid", evt_valid, (i > 0) ? 1 : 0);
        end
        evt_ready = 1'b0;
        check("q5_total", total, 6);

        // Test 4: saturation at 15 and overflow
        for (int i = 1; i <= 17; i++) send((i > 15) ? 15 : i, 6 + i, (i >= 16) ? 1 : 0);
        check("sat_pending", pending, 15);
        check("sat_overflow", overflow, 1);
        check("sat_total", total, 23);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("clr_overflow", overflow, 0);
        check("clr_pending", pending, 15);

        // Test 5: detect and pop in the same cycle
        evt_ready = 1'b1;
        repeat (12) tick();
        evt_ready = 1'b0;
        check("pend3", pending, 3);
        push(3, 24, 0);
        tog_in = ~tog_in;
        repeat (2) tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        tick();
        check("both_pending", pending, 3);
        check("both_total", total, 24);

        for (int i = 1; i <= 12; i++) send(3 + i, 24 + i, 0);
        send(15, 37, 1);
        // clear coincides with a saturated detect: set must win
        push(15, 38, 1);
        tog_in = ~tog_in;
        repeat (2) tick();
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        tick();
        check("setwins_overflow", overflow, 1);
        check("setwins_total", total, 38);

        // Test 6: reset, rearm, total wrap, then reset mid-stream
        rst = 1'b1;
        #1;
        check_all_zero("rst2");
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        check("rearm_armed", armed, 1);
        evt_ready = 1'b1;
        for (int i = 1; i <= 256; i++) send(1, i % 256, 0);
        check("wrap_total", total, 0);
        check("wrap_pending", pending, 0);
        check("wrap_overflow", overflow, 0);
        evt_ready = 1'b0;
        for (int i = 1; i <= 7; i++) send(i, i, 0);
        check("mid_pending", pending, 7);
        check("mid_scoreboard_empty", sb.size(), 0);
        rst = 1'b1;
        #1;
        check_all_zero("rst3");
        repeat (2) tick();
        check_all_zero("rst3_hold");
        rst = 1'b0;
        repeat (2) tick();
        check("rst3_init_armed", armed, 0);
        repeat (4) tick();
        check("rst3_rearm", armed, 1);
        check("rst3_pending", pending, 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
